// File: rtl/conv_mxi8tobf16.sv
// conv_mxi8tobf16
// Converts one MXINT block (k two's-complement elements with bit_width-2
// fraction bits, plus a shared E8M0 scale) into k BF16 values. Fully
// pipelined, stall-all datapath. The depth D (1..3) follows from freq_mhz.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_valid     input block valid
//   o_ready     converter accepts the input block this cycle (= advance)
//   i_mx_vec    k x bit_width MX elements, lane j at [j*bit_width +: bit_width]
//   i_mx_exp    shared scale X, E8M0 bias 127, 8'hFF = NaN
//   o_valid     output block valid
//   i_ready     downstream accepts the output block
//   o_bf16_vec  k x 16 BF16 results, lane j at [j*16 +: 16]
module conv_mxi8tobf16 #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int freq_mhz  = 100
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [k*bit_width-1:0] i_mx_vec,
  input  logic [7:0]             i_mx_exp,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [k*16-1:0]        o_bf16_vec
);

  localparam int D = (freq_mhz <= 100) ? 1 : (freq_mhz <= 200) ? 2 : 3;
  localparam logic signed [9:0] FRAC_W = 10'(bit_width - 2);
  localparam logic [15:0] BF16_NAN = 16'h7FC0;

  // One global advance: every stage moves together or every stage holds.
  logic advance;
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  // Magnitude as an unsigned bit_width value so that -2^(bit_width-1) fits.
  function automatic logic [7:0] f_mag(input logic [bit_width-1:0] e);
    logic [bit_width-1:0] a;
    a = e[bit_width-1] ? -e : e;
    return 8'(a);
  endfunction

  function automatic logic [2:0] f_lead(input logic [7:0] m);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) p = 3'(i);
    return p;
  endfunction

  function automatic logic signed [9:0] f_exp(input logic [7:0] x, input logic [2:0] p);
    return $signed({2'b00, x}) + $signed({7'b0, p}) - FRAC_W;
  endfunction

  // Leading one moved to bit 7; bits [6:0] are the BF16 mantissa.
  function automatic logic [7:0] f_norm(input logic [7:0] m, input logic [2:0] p);
    return m << (3'd7 - p);
  endfunction

  // Final selection: NaN, zero, overflow to infinity, normal, or
  // truncated subnormal (signed zero falls out when the shift empties it).
  function automatic logic [15:0] f_pack(input logic nan, input logic s,
                                         input logic signed [9:0] e,
                                         input logic [7:0] norm);
    logic signed [9:0] sh;
    logic [6:0]        sub;
    logic [15:0]       res;
    sh  = 10'sd1 - e;
    sub = 7'(norm >> sh);
    if (nan)                 res = BF16_NAN;
    else if (norm == 8'd0)   res = 16'h0000;
    else if (e >= 10'sd255)  res = {s, 8'hFF, 7'h00};
    else if (e >= 10'sd1)    res = {s, e[7:0], norm[6:0]};
    else                     res = {s, 8'h00, sub};
    return res;
  endfunction

  function automatic logic [15:0] f_convert(input logic [bit_width-1:0] e, input logic [7:0] x);
    logic [7:0] m;
    logic [2:0] p;
    m = f_mag(e);
    p = f_lead(m);
    return f_pack(x == 8'hFF, e[bit_width-1], f_exp(x, p), f_norm(m, p));
  endfunction

  if (D == 1) begin : g_d1
    logic            vld_p0;
    logic [k*16-1:0] bf16_p0;

    // Stage p0: complete conversion in one register stage.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        vld_p0  <= 1'b0;
        bf16_p0 <= '0;
      end else if (advance) begin
        vld_p0 <= i_valid;
        for (int j = 0; j < k; j++)
          bf16_p0[j*16 +: 16] <= f_convert(i_mx_vec[j*bit_width +: bit_width], i_mx_exp);
      end
    end

    assign o_valid    = vld_p0;
    assign o_bf16_vec = bf16_p0;
  end else begin : g_deep
    logic           vld_p0;
    logic [k-1:0]   s_p0;
    logic [7:0]     m_p0 [k];
    logic [2:0]     p_p0 [k];
    logic [7:0]     x_p0;
    logic           nan_p0;

    // Stage p0: sign, magnitude, leading-one position, scale, NaN flag.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)     vld_p0 <= 1'b0;
      else if (advance) vld_p0 <= i_valid;
    end

    always_ff @(posedge i_clk) begin
      if (advance) begin
        x_p0   <= i_mx_exp;
        nan_p0 <= (i_mx_exp == 8'hFF);
        for (int j = 0; j < k; j++) begin
          s_p0[j] <= i_mx_vec[j*bit_width + bit_width - 1];
          m_p0[j] <= f_mag(i_mx_vec[j*bit_width +: bit_width]);
          p_p0[j] <= f_lead(f_mag(i_mx_vec[j*bit_width +: bit_width]));
        end
      end
    end

    if (D == 2) begin : g_d2
      logic            vld_p1;
      logic [k*16-1:0] bf16_p1;

      // Stage p1: exponent, normalisation and pack.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          vld_p1  <= 1'b0;
          bf16_p1 <= '0;
        end else if (advance) begin
          vld_p1 <= vld_p0;
          for (int j = 0; j < k; j++)
            bf16_p1[j*16 +: 16] <= f_pack(nan_p0, s_p0[j], f_exp(x_p0, p_p0[j]),
                                          f_norm(m_p0[j], p_p0[j]));
        end
      end

      assign o_valid    = vld_p1;
      assign o_bf16_vec = bf16_p1;
    end else begin : g_d3
      logic                   vld_p1;
      logic [k-1:0]           s_p1;
      logic signed [9:0]      e_p1 [k];
      logic [7:0]             norm_p1 [k];
      logic                   nan_p1;
      logic                   vld_p2;
      logic [k*16-1:0]        bf16_p2;

      // Stage p1: biased exponent and normalised mantissa.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n)     vld_p1 <= 1'b0;
        else if (advance) vld_p1 <= vld_p0;
      end

      always_ff @(posedge i_clk) begin
        if (advance) begin
          nan_p1 <= nan_p0;
          s_p1   <= s_p0;
          for (int j = 0; j < k; j++) begin
            e_p1[j]    <= f_exp(x_p0, p_p0[j]);
            norm_p1[j] <= f_norm(m_p0[j], p_p0[j]);
          end
        end
      end

      // Stage p2: overflow / normal / subnormal selection and pack.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          vld_p2  <= 1'b0;
          bf16_p2 <= '0;
        end else if (advance) begin
          vld_p2 <= vld_p1;
          for (int j = 0; j < k; j++)
            bf16_p2[j*16 +: 16] <= f_pack(nan_p1, s_p1[j], e_p1[j], norm_p1[j]);
        end
      end

      assign o_valid    = vld_p2;
      assign o_bf16_vec = bf16_p2;
    end
  end

endmodule
